// File: rtl/sound_latch_pkg.sv
// Shared types and constants for the 68K <-> Z80 sound mailbox.
package sound_latch_pkg;

  typedef enum logic [1:0] {
    DT_IDLE = 2'd0,
    DT_WAIT = 2'd1,
    DT_ACK  = 2'd2
  } dtack_state_t;

  localparam logic [7:0]  Z80_ACK_VECTOR  = 8'hFF;
  // Bus addresses of the latch on each side; decoding happens upstream.
  localparam logic [15:0] Z80_LATCH_ADDR  = 16'hF800;
  localparam logic [23:0] M68K_LATCH_ADDR = 24'h0F8000;

endpackage

// File: rtl/mailbox_latch.sv
// One-deep 8-bit mailbox: a write edge loads data and sets pending,
// a read edge clears pending. A write in the same cycle as a read wins.
module mailbox_latch (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_wr_edge,
  input  logic       i_rd_edge,
  input  logic [7:0] i_din,
  output logic [7:0] o_data,
  output logic       o_pending
);

  logic [7:0] r_data;
  logic       r_pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data    <= '0;
      r_pending <= 1'b0;
    end else if (i_wr_edge) begin
      r_data    <= i_din;
      r_pending <= 1'b1;
    end else if (i_rd_edge) begin
      r_pending <= 1'b0;
    end
  end

  assign o_data    = r_data;
  assign o_pending = r_pending;

endmodule

// File: rtl/sound_latch_bridge.sv
// Command/reply mailbox between the 68K main CPU and the Z80 sound CPU,
// with Z80 interrupt generation and 68K DTACK timing for latch accesses.
module sound_latch_bridge
  import sound_latch_pkg::*;
#(
  parameter int unsigned NMI_MODE    = 0,
  parameter int unsigned NMI_PULSE   = 4,
  parameter int unsigned DTACK_DELAY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m68k_latch_cs,
  input  logic       z80_latch_read_cs,
  input  logic       m68k_as_n,
  input  logic       m68k_lds_n,
  input  logic [7:0] m68k_din,
  output logic [7:0] m68k_dout,
  output logic       m68k_dtack_n,
  input  logic       z80_latch_cs,
  input  logic       z80_rd_n,
  input  logic       z80_wr_n,
  input  logic       z80_iorq_n,
  input  logic       z80_m1_n,
  input  logic [7:0] z80_din,
  output logic [7:0] z80_dout,
  output logic       z80_int_n,
  output logic       z80_nmi_n,
  output logic       cmd_pending,
  output logic       reply_pending
);

  localparam logic [3:0] LP_NMI_PULSE   = 4'(NMI_PULSE);
  localparam logic [2:0] LP_DTACK_DELAY = 3'(DTACK_DELAY);

  logic w_m68k_wr, w_m68k_rd, w_z80_rd, w_z80_wr, w_z80_ack;
  logic w_m68k_wr_edge, w_m68k_rd_edge, w_z80_rd_edge, w_z80_wr_edge;
  logic r_m68k_wr_q, r_m68k_rd_q, r_z80_rd_q, r_z80_wr_q;
  logic [7:0] w_cmd_data, w_reply_data;
  logic       w_cmd_pending, w_reply_pending;

  assign w_m68k_wr = m68k_latch_cs & ~m68k_lds_n;
  assign w_m68k_rd = z80_latch_read_cs;
  assign w_z80_rd  = z80_latch_cs & ~z80_rd_n;
  assign w_z80_wr  = z80_latch_cs & ~z80_wr_n;
  assign w_z80_ack = ~z80_iorq_n & ~z80_m1_n;

  // Strobe history tracks through reset so a strobe held across reset
  // does not fire again; only a fresh 0->1 transition acts.
  always_ff @(posedge clk) begin
    r_m68k_wr_q <= w_m68k_wr;
    r_m68k_rd_q <= w_m68k_rd;
    r_z80_rd_q  <= w_z80_rd;
    r_z80_wr_q  <= w_z80_wr;
  end

  assign w_m68k_wr_edge = w_m68k_wr & ~r_m68k_wr_q;
  assign w_m68k_rd_edge = w_m68k_rd & ~r_m68k_rd_q;
  assign w_z80_rd_edge  = w_z80_rd  & ~r_z80_rd_q;
  assign w_z80_wr_edge  = w_z80_wr  & ~r_z80_wr_q;

  mailbox_latch u_cmd (
    .clk       (clk),
    .reset     (reset),
    .i_wr_edge (w_m68k_wr_edge),
    .i_rd_edge (w_z80_rd_edge),
    .i_din     (m68k_din),
    .o_data    (w_cmd_data),
    .o_pending (w_cmd_pending)
  );

  mailbox_latch u_reply (
    .clk       (clk),
    .reset     (reset),
    .i_wr_edge (w_z80_wr_edge),
    .i_rd_edge (w_m68k_rd_edge),
    .i_din     (z80_din),
    .o_data    (w_reply_data),
    .o_pending (w_reply_pending)
  );

  logic [7:0] r_m68k_dout, r_z80_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_m68k_dout <= '0;
      r_z80_dout  <= '0;
    end else begin
      if (w_m68k_rd_edge) r_m68k_dout <= w_reply_data;
      if (w_z80_ack)          r_z80_dout <= Z80_ACK_VECTOR;
      else if (w_z80_rd_edge) r_z80_dout <= w_cmd_data;
    end
  end

  dtack_state_t r_dt_state;
  logic [2:0]   r_dt_cnt;
  logic         r_dtack_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dt_state <= DT_IDLE;
      r_dt_cnt   <= '0;
      r_dtack_n  <= 1'b1;
    end else begin
      case (r_dt_state)
        DT_IDLE: begin
          if (w_m68k_wr_edge | w_m68k_rd_edge) begin
            if (LP_DTACK_DELAY == 3'd0) begin
              r_dt_state <= DT_ACK;
              r_dtack_n  <= 1'b0;
            end else begin
              r_dt_state <= DT_WAIT;
              r_dt_cnt   <= LP_DTACK_DELAY;
            end
          end
        end
        DT_WAIT: begin
          if (m68k_as_n) begin
            r_dt_state <= DT_IDLE;
            r_dt_cnt   <= '0;
          end else begin
            r_dt_cnt <= r_dt_cnt - 3'd1;
            if (r_dt_cnt == 3'd1) begin
              r_dt_state <= DT_ACK;
              r_dtack_n  <= 1'b0;
            end
          end
        end
        DT_ACK: begin
          if (m68k_as_n) begin
            r_dt_state <= DT_IDLE;
            r_dtack_n  <= 1'b1;
          end
        end
        default: begin
          r_dt_state <= DT_IDLE;
          r_dtack_n  <= 1'b1;
        end
      endcase
    end
  end

  logic [3:0] r_nmi_cnt, w_nmi_cnt_next;
  logic       r_nmi_n, r_int_n;

  always_comb begin
    w_nmi_cnt_next = r_nmi_cnt;
    if (NMI_MODE != 0) begin
      if (w_m68k_wr_edge)           w_nmi_cnt_next = LP_NMI_PULSE;
      else if (r_nmi_cnt != 4'd0)   w_nmi_cnt_next = r_nmi_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_nmi_cnt <= '0;
      r_nmi_n   <= 1'b1;
      r_int_n   <= 1'b1;
    end else begin
      r_nmi_cnt <= w_nmi_cnt_next;
      r_nmi_n   <= (w_nmi_cnt_next == 4'd0);
      r_int_n   <= (NMI_MODE != 0) ? 1'b1 : ~w_cmd_pending;
    end
  end

  assign m68k_dout     = r_m68k_dout;
  assign m68k_dtack_n  = r_dtack_n;
  assign z80_dout      = r_z80_dout;
  assign z80_int_n     = r_int_n;
  assign z80_nmi_n     = r_nmi_n;
  assign cmd_pending   = w_cmd_pending;
  assign reply_pending = w_reply_pending;

endmodule

// File: tb/tb_sound_latch_bridge.sv
// Scoreboard bench: two bridges share stimulus, one in IRQ mode with a
// 4-cycle DTACK delay, one in NMI mode with zero DTACK delay.
module tb_sound_latch_bridge;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       m68k_latch_cs = 1'b0, z80_latch_read_cs = 1'b0;
  logic       m68k_as_n = 1'b1, m68k_lds_n = 1'b1;
  logic [7:0] m68k_din = '0, z80_din = '0;
  logic       z80_latch_cs = 1'b0, z80_rd_n = 1'b1, z80_wr_n = 1'b1;
  logic       z80_iorq_n = 1'b1, z80_m1_n = 1'b1;

  logic [7:0] m68k_dout_a, z80_dout_a, m68k_dout_b, z80_dout_b;
  logic       dtack_a, int_a, nmi_a, cmdp_a, repp_a;
  logic       dtack_b, int_b, nmi_b, cmdp_b, repp_b;

  always #5 clk = ~clk;

  sound_latch_bridge #(.NMI_MODE(0), .NMI_PULSE(4), .DTACK_DELAY(4)) u_dut_a (
    .clk(clk), .reset(reset), .m68k_latch_cs(m68k_latch_cs),
    .z80_latch_read_cs(z80_latch_read_cs), .m68k_as_n(m68k_as_n),
    .m68k_lds_n(m68k_lds_n), .m68k_din(m68k_din), .m68k_dout(m68k_dout_a),
    .m68k_dtack_n(dtack_a), .z80_latch_cs(z80_latch_cs), .z80_rd_n(z80_rd_n),
    .z80_wr_n(z80_wr_n), .z80_iorq_n(z80_iorq_n), .z80_m1_n(z80_m1_n),
    .z80_din(z80_din), .z80_dout(z80_dout_a), .z80_int_n(int_a),
    .z80_nmi_n(nmi_a), .cmd_pending(cmdp_a), .reply_pending(repp_a)
  );

  sound_latch_bridge #(.NMI_MODE(1), .NMI_PULSE(4), .DTACK_DELAY(0)) u_dut_b (
    .clk(clk), .reset(reset), .m68k_latch_cs(m68k_latch_cs),
    .z80_latch_read_cs(z80_latch_read_cs), .m68k_as_n(m68k_as_n),
    .m68k_lds_n(m68k_lds_n), .m68k_din(m68k_din), .m68k_dout(m68k_dout_b),
    .m68k_dtack_n(dtack_b), .z80_latch_cs(z80_latch_cs), .z80_rd_n(z80_rd_n),
    .z80_wr_n(z80_wr_n), .z80_iorq_n(z80_iorq_n), .z80_m1_n(z80_m1_n),
    .z80_din(z80_din), .z80_dout(z80_dout_b), .z80_int_n(int_b),
    .z80_nmi_n(nmi_b), .cmd_pending(cmdp_b), .reply_pending(repp_b)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [7:0]  sb_cmd[$];
  logic [7:0]  sb_reply[$];
  logic [7:0]  m_cmd = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_cmdp",   {cmdp_b, cmdp_a}, 0);
    chk("rst_repp",   {repp_b, repp_a}, 0);
    chk("rst_m68k_d", {m68k_dout_b, m68k_dout_a}, 0);
    chk("rst_z80_d",  {z80_dout_b, z80_dout_a}, 0);
    chk("rst_dtack",  {dtack_b, dtack_a}, 2'b11);
    chk("rst_int",    {int_b, int_a}, 2'b11);
    chk("rst_nmi",    {nmi_b, nmi_a}, 2'b11);
  endtask

  task automatic m68k_write(input logic [7:0] d);
    m68k_din = d; m68k_latch_cs = 1'b1; m68k_lds_n = 1'b0; m68k_as_n = 1'b0;
    tick(6);
    chk("wr_dtack_low", {dtack_b, dtack_a}, 2'b00);
    m68k_latch_cs = 1'b0; m68k_lds_n = 1'b1; m68k_as_n = 1'b1;
    tick(1);
    chk("wr_dtack_high", {dtack_b, dtack_a}, 2'b11);
    m_cmd = d;
    tick(1);
  endtask

  task automatic z80_read();
    logic [7:0] exp;
    sb_cmd.push_back(m_cmd);
    z80_latch_cs = 1'b1; z80_rd_n = 1'b0;
    tick(1);
    exp = sb_cmd.pop_front();
    chk("z80_rd_data_a", z80_dout_a, exp);
    chk("z80_rd_data_b", z80_dout_b, exp);
    chk("z80_rd_clr",    {cmdp_b, cmdp_a}, 2'b00);
    tick(2);
    chk("z80_rd_hold",   z80_dout_a, exp);
    z80_latch_cs = 1'b0; z80_rd_n = 1'b1;
    tick(2);
    chk("int_released",  int_a, 1'b1);
  endtask

  task automatic nmi_burst(input logic [7:0] d, input bit second, output int low);
    low = 0; m68k_din = d; m68k_as_n = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      m68k_latch_cs = (k == 1) || (second && k == 3);
      m68k_lds_n    = ~m68k_latch_cs;
      tick(1);
      if (!nmi_b) low++;
    end
    m68k_latch_cs = 1'b0; m68k_lds_n = 1'b1; m68k_as_n = 1'b1;
    m_cmd = d;
    tick(2);
  endtask

  initial begin
    int low;
    logic [7:0] exp;

    tick(3);
    chk_reset_state();
    reset = 1'b0;
    tick(1);

    // 68K write 0x5A held 10 cycles; din changes mid-access must not relatch
    m68k_din = 8'h5A; m68k_latch_cs = 1'b1; m68k_lds_n = 1'b0; m68k_as_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (k == 1) chk("cmdp_set", {cmdp_b, cmdp_a}, 2'b11);
      if (k == 3) m68k_din = 8'hEE;
      chk("dtack_a_timing", dtack_a, (k >= 5) ? 1'b0 : 1'b1);
      chk("dtack_b_timing", dtack_b, 1'b0);
      chk("nmi_b_pulse",    nmi_b, (k <= 4) ? 1'b0 : 1'b1);
    end
    chk("int_a_asserted", int_a, 1'b0);
    chk("int_b_held",     int_b, 1'b1);
    chk("nmi_a_held",     nmi_a, 1'b1);
    m68k_latch_cs = 1'b0; m68k_lds_n = 1'b1; m68k_as_n = 1'b1;
    tick(1);
    chk("dtack_release",  {dtack_b, dtack_a}, 2'b11);
    m_cmd = 8'h5A;
    tick(1);
    z80_read();

    // IRQ mode: acknowledge returns vector and leaves pending set
    m68k_write(8'h33);
    chk("int_a_cmd33", int_a, 1'b0);
    z80_iorq_n = 1'b0; z80_m1_n = 1'b0;
    tick(1);
    chk("ack_vector", z80_dout_a, 8'hFF);
    z80_iorq_n = 1'b1; z80_m1_n = 1'b1;
    tick(1);
    chk("ack_keeps_pend", cmdp_a, 1'b1);
    chk("ack_keeps_int",  int_a, 1'b0);
    z80_read();

    // NMI pulse width, then extension by a second write two cycles later
    nmi_burst(8'h01, 1'b0, low);
    chk("nmi_width_single", low, 4);
    nmi_burst(8'h02, 1'b1, low);
    chk("nmi_width_ext", low, 6);
    z80_read();

    // Reply path
    sb_reply.push_back(8'hA7);
    z80_din = 8'hA7; z80_latch_cs = 1'b1; z80_wr_n = 1'b0;
    tick(1);
    chk("repp_set", {repp_b, repp_a}, 2'b11);
    z80_latch_cs = 1'b0; z80_wr_n = 1'b1;
    tick(1);
    z80_latch_read_cs = 1'b1; m68k_as_n = 1'b0;
    tick(1);
    exp = sb_reply.pop_front();
    chk("m68k_rd_data_a", m68k_dout_a, exp);
    chk("m68k_rd_data_b", m68k_dout_b, exp);
    chk("repp_clr", {repp_b, repp_a}, 2'b00);
    chk("rd_dtack_b", dtack_b, 1'b0);
    tick(4);
    chk("rd_dtack_a", dtack_a, 1'b0);
    z80_latch_read_cs = 1'b0; m68k_as_n = 1'b1;
    tick(2);
    chk("rd_dtack_rel", {dtack_b, dtack_a}, 2'b11);

    // Same-cycle 68K write and Z80 read: Z80 sees old data, write wins
    m68k_write(8'h11);
    sb_cmd.push_back(m_cmd);
    m68k_din = 8'h99; m68k_latch_cs = 1'b1; m68k_lds_n = 1'b0; m68k_as_n = 1'b0;
    z80_latch_cs = 1'b1; z80_rd_n = 1'b0;
    tick(1);
    exp = sb_cmd.pop_front();
    chk("coll_old_data", z80_dout_a, exp);
    chk("coll_pending",  cmdp_a, 1'b1);
    m68k_latch_cs = 1'b0; m68k_lds_n = 1'b1; m68k_as_n = 1'b1;
    z80_latch_cs = 1'b0; z80_rd_n = 1'b1;
    m_cmd = 8'h99;
    tick(2);
    z80_read();

    // Reset during DTACK wait and mid NMI pulse
    m68k_din = 8'h77; m68k_latch_cs = 1'b1; m68k_lds_n = 1'b0; m68k_as_n = 1'b0;
    tick(3);
    chk("pre_rst_wait",  dtack_a, 1'b1);
    chk("pre_rst_nmi",   nmi_b, 1'b0);
    reset = 1'b1;
    tick(1);
    chk_reset_state();
    reset = 1'b0;
    m68k_latch_cs = 1'b0; m68k_lds_n = 1'b1; m68k_as_n = 1'b1;
    tick(2);
    chk("post_rst_idle", {dtack_b, dtack_a}, 2'b11);
    m68k_write(8'h42);
    chk("post_rst_cmdp", cmdp_a, 1'b1);
    z80_read();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sound_latch_bridge.md
Name: sound_latch_bridge

Overview:
- Bidirectional mailbox between the M68K main CPU and the Z80 sound CPU.
- The 68K writes the command latch; the Z80 reads it at 0xF800. The Z80 writes the reply latch at 0xF800; the 68K reads it at 0x0F8000.
- Driven by the decoded selects from the chip-select decoder. Generates the Z80 sound interrupt (IRQ or NMI) and the 68K DTACK_n for latch accesses.
- Replaces the bare latch wiring in the top level.

Parameters:
- NMI_MODE, 0, 0: level IRQ (z80_int_n) while a command is pending; 1: NMI pulse on each command write.
- NMI_PULSE, 4, NMI low width in clk cycles, range 1..15.
- DTACK_DELAY, 2, clk cycles from select qualification to DTACK_n low, range 0..7.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m68k_latch_cs  in  1  68K command-latch write select (already write-qualified)
- z80_latch_read_cs  in  1  68K reply-latch read select
- m68k_as_n  in  1  68K address strobe
- m68k_lds_n  in  1  68K lower data strobe
- m68k_din  in  8  68K data bus, low byte
- m68k_dout  out  8  reply-latch data to 68K
- m68k_dtack_n  out  1  DTACK for latch accesses; 1 when idle
- z80_latch_cs  in  1  Z80 access to 0xF800
- z80_rd_n  in  1  Z80 RD_n
- z80_wr_n  in  1  Z80 WR_n
- z80_iorq_n  in  1  Z80 IORQ_n
- z80_m1_n  in  1  Z80 M1_n
- z80_din  in  8  Z80 data out
- z80_dout  out  8  command data, or vector 0xFF during interrupt acknowledge
- z80_int_n  out  1  Z80 maskable interrupt
- z80_nmi_n  out  1  Z80 NMI
- cmd_pending  out  1  command written, not yet read by Z80
- reply_pending  out  1  reply written, not yet read by 68K

Behaviour:
- Reset values: cmd_data=0x00, reply_data=0x00, both pending flags 0, m68k_dout=0x00, z80_dout=0x00, m68k_dtack_n=1, z80_int_n=1, z80_nmi_n=1, DTACK FSM in IDLE, NMI counter 0. Reset mid-operation aborts the cycle; the cycle restarts from IDLE on the next qualifying edge.
- Edge qualification: every bus access spans many clk cycles, so each access acts exactly once.
  - Register each qualified strobe; act on its 0->1 transition.
  - 68K write strobe = m68k_latch_cs & !m68k_lds_n. 68K read strobe = z80_latch_read_cs. Z80 read = z80_latch_cs & !z80_rd_n. Z80 write = z80_latch_cs & !z80_wr_n.
- Command path:
  - On the 68K write edge: cmd_data <= m68k_din and cmd_pending <= 1, both visible on the next cycle.
  - On the Z80 read edge: z80_dout = cmd_data (registered, valid from the edge cycle +1 until RD_n rises), and cmd_pending <= 0.
  - 68K write edge and Z80 read edge in the same cycle: the Z80 gets the old data, and the write wins (pending=1, new data).
  - A 68K write while already pending overwrites the data; there is no queue.
- Reply path:
  - On the Z80 write edge: reply_data <= z80_din and reply_pending <= 1.
  - On the 68K read edge: m68k_dout = reply_data and reply_pending <= 0.
  - Simultaneous events resolve as in the command path: the write wins.
- Interrupt, NMI_MODE=0:
  - z80_int_n = !cmd_pending, registered.
  - Acknowledge cycle (!z80_iorq_n & !z80_m1_n): z80_dout = 0xFF. The acknowledge does not clear pending; only the Z80 data read clears it.
- Interrupt, NMI_MODE=1:
  - z80_int_n is held at 1.
  - Each 68K write edge loads the NMI counter with NMI_PULSE; z80_nmi_n = (counter==0). The counter decrements to 0.
  - A write during an active pulse reloads the counter, extending the pulse.
- DTACK FSM:
  - IDLE: on a 68K write or read edge, go to WAIT and load the delay counter with DTACK_DELAY.
  - WAIT: decrement the counter; at 0, go to ACK. With DTACK_DELAY=0, go straight from IDLE to ACK.
  - ACK: m68k_dtack_n=0. Return to IDLE when m68k_as_n=1.
  - An AS_n rise while in WAIT returns the FSM to IDLE without acknowledging.

Decomposition:
- Shared package sound_latch_pkg: DTACK state enum (IDLE/WAIT/ACK), Z80_ACK_VECTOR=8'hFF, latch address localparams 0xF800 and 0x0F8000 for documentation alignment.
- One natural sub-module: mailbox_latch, instantiated twice (command, reply). It holds the 8-bit data register, the pending flag, write/read edge inputs and the write-wins rule.

Test Plan:
- 68K writes 0x5A, AS_n held 10 cycles -> cmd_pending=1 after 1 cycle; a single latch occurs; DTACK_n low exactly DTACK_DELAY+1 cycles after the strobe edge, high after AS_n rises.
- NMI_MODE=0: command 0x33 written -> z80_int_n=0; IORQ_n/M1_n acknowledge -> z80_dout=0xFF; Z80 read -> z80_dout=0x33, then z80_int_n=1.
- NMI_MODE=1, NMI_PULSE=4: write 0x01 -> z80_nmi_n low for exactly 4 cycles; a second write at cycle 2 -> low for 6 cycles total.
- Z80 writes 0xA7 -> reply_pending=1; 68K read -> m68k_dout=0xA7, reply_pending=0, DTACK asserted.
- Same-cycle 68K write of 0x99 and Z80 read with cmd_data=0x11 -> Z80 sees 0x11; cmd_pending stays 1 and cmd_data=0x99.
- Reset asserted while in WAIT and while the NMI counter is 2 -> next cycle all outputs at reset values; a following write completes normally.
